// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Ain - Bin computed LSB first through one
// full-subtractor cell and a registered borrow, one bit per clock.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Dout,
  output logic             Bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Single full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic r);
    logic d;
    logic rn;
    d  = a ^ b ^ r;
    rn = (~a & b) | (~(a ^ b) & r);
    return {rn, d};
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic [WIDTH-1:0] res_r, res_s;
  logic             borrow_r, borrow_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] dout_s;
  logic             bout_s;
  logic             busy_s;
  logic             done_s;
  logic [1:0]       fs_s;

  // Next-state, datapath and output-register next values.
  always_comb begin
    state_s  = state_r;
    a_s      = a_r;
    b_s      = b_r;
    res_s    = res_r;
    borrow_s = borrow_r;
    cnt_s    = cnt_r;
    dout_s   = Dout;
    bout_s   = Bout;
    fs_s     = full_sub(a_r[0], b_r[0], borrow_r);

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_s  = ST_RUN;
          a_s      = Ain;
          b_s      = Bin;
          res_s    = {WIDTH{1'b0}};
          borrow_s = 1'b0;
          cnt_s    = CNT_ZERO;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_s      = {1'b0, a_r[WIDTH-1:1]};
        b_s      = {1'b0, b_r[WIDTH-1:1]};
        res_s    = {fs_s[0], res_r[WIDTH-1:1]};
        borrow_s = fs_s[1];
        cnt_s    = cnt_r + CNT_ONE;
        // The result register is kept apart from Dout so partials never show.
        if (cnt_r == CNT_LAST) begin
          state_s = ST_DONE;
          dout_s  = {fs_s[0], res_r[WIDTH-1:1]};
          bout_s  = fs_s[1];
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s == ST_RUN);
    done_s = (state_s == ST_DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r  <= ST_IDLE;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      res_r    <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      cnt_r    <= CNT_ZERO;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Dout     <= {WIDTH{1'b0}};
      Bout     <= 1'b0;
    end else begin
      state_r  <= state_s;
      a_r      <= a_s;
      b_r      <= b_s;
      res_r    <= res_s;
      borrow_r <= borrow_s;
      cnt_r    <= cnt_s;
      Busy     <= busy_s;
      Done     <= done_s;
      Dout     <= dout_s;
      Bout     <= bout_s;
    end
  end

endmodule
